// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding load or store, word-aligned DMem accesses,
// read-modify-write for byte/halfword stores, extended load data on response.
module load_store_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;
  logic [31:0] wword_q;
  logic        req_err;
  logic        accept;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    if (req_write) begin
      req_err = (req_funct3 > 3'd2)
             || (req_funct3 == 3'd1 && req_addr[0])
             || (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00);
    end else begin
      case (req_funct3)
        3'd1, 3'd5:       req_err = req_addr[0];
        3'd2:             req_err = (req_addr[1:0] != 2'b00);
        3'd3, 3'd6, 3'd7: req_err = 1'b1;
        default:          req_err = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                                 state_next = RESP;
          else if (req_write && req_funct3 == 3'd2)    state_next = WR;
          else                                         state_next = RD;
        end
      end
      RD:      state_next = write_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sub-word store: splice the new lane into the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (funct3_q[1:0] == 2'd1)
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_ext = word_q;
      3'd4:    load_ext = {24'h0, byte_sel};
      3'd5:    load_ext = {16'h0, half_sel};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      wword_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        write_q  <= req_write;
        wdata_q  <= req_wdata[15:0];
        err_q    <= req_err;
        if (req_write && req_funct3 == 3'd2) wword_q <= req_wdata;
      end
      if (state == RD) begin
        word_q <= mem_rdata;
        if (write_q) wword_q <= merged;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_we    = (state == WR);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wword_q;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP && !err_q && !write_q) ? load_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model plus per-cycle expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];

  bit          exp_busy  [int];
  bit          exp_rsp   [int];
  logic [31:0] exp_rdata [int];
  bit          exp_err   [int];
  bit          exp_we    [int];
  logic [31:0] exp_wa    [int];
  logic [31:0] exp_wd    [int];

  typedef struct {
    bit          err;
    int          lat;
    bit          wr;
    logic [31:0] rdata;
    logic [31:0] nword;
  } res_t;

  load_store_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  function automatic res_t model(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] wd, input bit [31:0] word);
    res_t r;
    int   v, nb, base;
    r.rdata = '0;
    r.nword = word;
    if (w) r.err = (f3 > 2) || (f3 == 1 && a[0]) || (f3 == 2 && a[1:0] != 0);
    else   r.err = (f3 == 3 || f3 == 6 || f3 == 7) || ((f3 == 1 || f3 == 5) && a[0])
                || (f3 == 2 && a[1:0] != 0);
    r.wr  = w && !r.err;
    r.lat = r.err ? 1 : (!w ? 2 : (f3 == 2 ? 2 : 3));
    if (!r.err && !w) begin
      case (f3)
        3'd0, 3'd4: begin
          v = int'((word >> (8 * int'(a[1:0]))) & 32'hFF);
          if (f3 == 0 && v >= 128) v = v - 256;
        end
        3'd1, 3'd5: begin
          v = int'((word >> (16 * int'(a[1]))) & 32'hFFFF);
          if (f3 == 1 && v >= 32768) v = v - 65536;
        end
        default: v = int'(word);
      endcase
      r.rdata = 32'(v);
    end
    if (r.wr) begin
      nb   = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
      base = (f3 == 0) ? int'(a[1:0]) : (f3 == 1) ? 2 * int'(a[1]) : 0;
      for (int i = 0; i < nb; i++) r.nword[(base + i) * 8 +: 8] = wd[i * 8 +: 8];
    end
    return r;
  endfunction

  // lit_kind: 0 none, 1 rsp_rdata on response, 2 mem_wdata on write, 3 rsp_err on response
  task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input bit keep, input int lit_kind, input bit [31:0] lit);
    res_t r;
    int   e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    r = model(w, f3, a, wd, ref_mem[a[9:2]]);
    e = cyc + 1;
    for (int k = 0; k < r.lat; k++) exp_busy[e + k] = 1;
    exp_rsp[e + r.lat - 1]   = 1;
    exp_rdata[e + r.lat - 1] = r.rdata;
    exp_err[e + r.lat - 1]   = r.err;
    if (r.wr) begin
      exp_we[e + r.lat - 2] = 1;
      exp_wa[e + r.lat - 2] = {a[31:2], 2'b00};
      exp_wd[e + r.lat - 2] = r.nword;
      ref_mem[a[9:2]] = r.nword;
    end
    @(posedge clk);
    for (int k = 0; k < r.lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep) req_wdata = 32'hDEADBEEF;
        else      req_valid = 1'b0;
      end
      if (lit_kind == 1 && k == r.lat - 1) chk("lit_rdata", rsp_rdata, lit);
      if (lit_kind == 3 && k == r.lat - 1) chk("lit_err", {31'b0, rsp_err}, lit);
      if (lit_kind == 2 && k == r.lat - 2) chk("lit_wdata", mem_wdata, lit);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && started) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !exp_busy.exists(cyc)});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp.exists(cyc)});
      if (exp_rsp.exists(cyc)) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata[cyc]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err[cyc]});
      end else begin
        chk("idle_rdata", rsp_rdata, 32'h0);
        chk("idle_err", {31'b0, rsp_err}, 32'h0);
      end
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we.exists(cyc)});
      if (exp_we.exists(cyc)) begin
        chk("mem_addr", mem_addr, exp_wa[cyc]);
        chk("mem_wdata", mem_wdata, exp_wd[cyc]);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    dmem[idx]    = val;
    ref_mem[idx] = val;
  endtask

  initial begin
    int e;
    for (int i = 0; i < 256; i++) preload(i, 32'(i) * 32'h01010101);
    preload(64, 32'h8899AABB);
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk); rstn = 1'b1; started = 1;

    do_req(0, 3'd0, 32'h101, 0, 0, 1, 32'hFFFFFFAA);
    do_req(0, 3'd4, 32'h103, 0, 0, 1, 32'h00000088);
    do_req(0, 3'd5, 32'h102, 0, 0, 1, 32'h00008899);
    do_req(0, 3'd1, 32'h102, 0, 0, 1, 32'hFFFF8899);
    do_req(1, 3'd0, 32'h102, 32'h12345678, 0, 2, 32'h8878AABB);
    chk("sb_mem", dmem[64], 32'h8878AABB);

    preload(64, 32'h8899AABB);
    do_req(1, 3'd1, 32'h100, 32'h0000CAFE, 0, 0, 0);
    chk("sh_mem", dmem[64], 32'h8899CAFE);
    do_req(0, 3'd1, 32'h100, 0, 0, 1, 32'hFFFFCAFE);
    do_req(0, 3'd2, 32'h100, 0, 0, 1, 32'h8899CAFE);

    do_req(0, 3'd2, 32'h102, 0, 0, 3, 32'h1);
    do_req(1, 3'd1, 32'h101, 32'h1111, 0, 3, 32'h1);
    do_req(0, 3'd3, 32'h100, 0, 0, 3, 32'h1);
    do_req(1, 3'd3, 32'h104, 32'h1, 0, 3, 32'h1);
    do_req(0, 3'd5, 32'h10B, 0, 0, 3, 32'h1);

    do_req(0, 3'd0, 32'h10C, 0, 0, 0, 0);
    do_req(1, 3'd0, 32'h10F, 32'hA5, 0, 0, 0);
    do_req(0, 3'd4, 32'h10F, 0, 0, 1, 32'h000000A5);

    // Reset in the read phase of a byte store: no write may land.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h100; req_wdata = 32'h55;
    e = cyc + 1;
    exp_busy[e] = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("abort_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1 chk("abort_we_edge", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = e; k < e + 4; k++) begin
      exp_busy.delete(k); exp_rsp.delete(k); exp_we.delete(k);
    end
    chk("abort_mem", dmem[64], 32'h8899CAFE);

    // Back-to-back stores with req_valid held; second accepted only once idle again.
    do_req(1, 3'd2, 32'h110, 32'h01020304, 1, 0, 0);
    do_req(1, 3'd2, 32'h114, 32'hCAFEF00D, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("b2b_mem0", dmem[68], 32'h01020304);
    chk("b2b_mem1", dmem[69], 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
